dm_lsu: RTL and testbench

Load/store unit for the RV32I core. It sits between the datapath's memory stage and a word-wide data-memory bus. It consumes MemRead, MemWrite and DMType from the main decoder, plus the ALU address and rs2 data, and runs one bus transaction per access with a request/acknowledge handshake. While the access is outstanding it stalls the pipeline. It also handles sub-word lane steering, byte enables, load sign/zero extension, misalignment detection and a bus-timeout watchdog.

---
 rtl/dm_lsu.sv | 168 ++++++++++++++++
 tb/tb_dm_lsu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// Load/store unit: one word-bus transaction per MemRead/MemWrite, with lane
// steering, byte enables, load extension, misalignment trap and a bus watchdog.
module dm_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  DMType,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        is_byte_q;
  logic        is_half_q;
  logic        uns_q;
  logic [1:0]  off_q;

  logic        is_byte;
  logic        is_half;
  logic        start;
  logic        misaligned;
  logic        accept;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  // Handshake: bus_req rises the cycle after an accepted start and stays high,
  // with we/addr/wdata/be frozen, until the edge that samples bus_ack=1 (or
  // the watchdog fires). bus_ack seen while bus_req is low has no effect.

  assign is_byte    = DMType[0];
  assign is_half    = ~DMType[0] & DMType[1];
  assign start      = MemRead | MemWrite;
  assign misaligned = (is_half & addr[0]) | (~is_byte & ~is_half & (addr[1:0] != 2'b00));
  assign accept     = (state == IDLE) & start & ~misaligned;

  assign misalign  = (state == IDLE) & start & misaligned;
  assign stall     = accept | (state == BUSY);
  assign state_dbg = state;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    if (is_byte) begin
      be_next    = 4'b0001 << addr[1:0];
      wdata_next = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_next    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    byte_sel = bus_rdata[7:0];
    case (off_q)
      2'd0: byte_sel = bus_rdata[7:0];
      2'd1: byte_sel = bus_rdata[15:8];
      2'd2: byte_sel = bus_rdata[23:16];
      2'd3: byte_sel = bus_rdata[31:24];
      default: byte_sel = bus_rdata[7:0];
    endcase
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    if (is_byte_q) begin
      load_val = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (is_half_q) begin
      load_val = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end else begin
      load_val = bus_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= 4'b0000;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      is_byte_q   <= 1'b0;
      is_half_q   <= 1'b0;
      uns_q       <= 1'b0;
      off_q       <= 2'd0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUSY;
            cnt       <= '0;
            bus_req   <= 1'b1;
            bus_we    <= MemWrite;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= wdata_next;
            bus_be    <= be_next;
            is_byte_q <= is_byte;
            is_half_q <= is_half;
            uns_q     <= DMType[2];
            off_q     <= addr[1:0];
          end
        end
        BUSY: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdata       <= load_val;
              rdata_valid <= 1'b1;
            end
          end else if (cnt == LAST_CNT) begin
            state   <= DONE;
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            // An abandoned load returns zero; an abandoned store keeps rdata.
            if (!bus_we) rdata <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_req_busy: assert property (@(posedge clk) disable iff (rst)
    bus_req == (state == BUSY));

  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (bus_req && $past(bus_req)) |->
      ($stable(bus_addr) && $stable(bus_wdata) && $stable(bus_be) && $stable(bus_we)));

  a_pulse_excl: assert property (@(posedge clk) disable iff (rst)
    !(rdata_valid && bus_err));

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: a table of single accesses with hand-computed
// bus/rdata results, plus reset and watchdog corner sequences.
module tb_dm_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  dm_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  int cur_vec = -1;
  logic [31:0] exp_q[$];

  dm_lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .MemRead(mem_read), .MemWrite(mem_write), .DMType(dm_type),
    .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  dm;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] brd;
    int          ack_cyc;   // 0 = never ack
    logic        mis;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_rdata;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] dm, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] brd, int ack_cyc, logic mis,
                              logic [31:0] e_addr, logic [31:0] e_wdata, logic [3:0] e_be,
                              logic e_we, logic [31:0] e_rdata, logic e_valid, logic e_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.dm = dm; v.a = a; v.wd = wd; v.brd = brd;
    v.ack_cyc = ack_cyc; v.mis = mis; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_be = e_be; v.e_we = e_we; v.e_rdata = e_rdata; v.e_valid = e_valid;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL v%0d %s: got %h expected %h", cur_vec, name, act, exp);
    end
  endtask

  // scoreboard: every rdata_valid pulse must match the next expected load
  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL v%0d unexpected_rdata_valid: got rdata %h expected no pulse", cur_vec, rdata);
      end else begin
        chk("sb_rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    mem_read = 1'b0; mem_write = 1'b0; dm_type = 3'd0; addr = '0; wdata = '0;
  endtask

  // driver: one access, inputs held while stalled and through DONE
  task automatic run_vec(input vec_t v);
    int done_cyc;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; dm_type = v.dm; addr = v.a; wdata = v.wd;
    bus_ack = 1'b0;
    #1;
    chk("misalign_c0", 32'(misalign), 32'(v.mis));
    chk("stall_c0", 32'(stall), 32'(!v.mis));
    if (v.mis) begin
      chk("bus_req_mis", 32'(bus_req), 32'd0);
      @(negedge clk);
      #1;
      chk("state_mis", 32'(state_dbg), 32'd0);
      chk("bus_req_mis_c1", 32'(bus_req), 32'd0);
      clear_inputs();
      return;
    end
    if (v.e_valid) exp_q.push_back(v.e_rdata);
    done_cyc = (v.ack_cyc >= 1 && v.ack_cyc <= TMO) ? v.ack_cyc + 1 : TMO + 1;
    for (int c = 1; c < done_cyc; c++) begin
      @(negedge clk);
      bus_ack   = (c == v.ack_cyc);
      bus_rdata = (c == v.ack_cyc) ? v.brd : $urandom();
      #1;
      chk("bus_req_busy", 32'(bus_req), 32'd1);
      chk("stall_busy", 32'(stall), 32'd1);
      chk("bus_addr", bus_addr, v.e_addr);
      chk("bus_we", 32'(bus_we), 32'(v.e_we));
      chk("bus_be", 32'(bus_be), 32'(v.e_be));
      chk("bus_wdata", bus_wdata, v.e_wdata);
    end
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = $urandom();
    #1;
    chk("stall_done", 32'(stall), 32'd0);
    chk("bus_req_done", 32'(bus_req), 32'd0);
    chk("state_done", 32'(state_dbg), 32'd2);
    chk("rdata_valid", 32'(rdata_valid), 32'(v.e_valid));
    chk("bus_err", 32'(bus_err), 32'(v.e_err));
    chk("rdata", rdata, v.e_rdata);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("state_after", 32'(state_dbg), 32'd0);
    chk("pulses_after", {30'd0, rdata_valid, bus_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = '0;
    clear_inputs();

    //   rd wr dm      addr          wdata          bus_rdata      ack mis e_addr        e_wdata        be       we e_rdata        val err
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         1, 0, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 1, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0203, 32'h0,         32'h80FF_0000, 3, 0, 32'h0000_0200, 32'h0,         4'b1000, 0, 32'hFFFF_FF80, 1, 0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0203, 32'h0,         32'h80FF_0000, 3, 0, 32'h0000_0200, 32'h0,         4'b1000, 0, 32'h0000_0080, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0302, 32'h1234_ABCD, 32'h0,         2, 0, 32'h0000_0300, 32'hABCD_ABCD, 4'b1100, 1, 32'h0000_0080, 0, 0));
    vecs.push_back(mk(1, 0, 3'b110, 32'h0000_0302, 32'h0,         32'hABCD_0000, 1, 0, 32'h0000_0300, 32'h0,         4'b1100, 0, 32'h0000_ABCD, 1, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0401, 32'h0,         32'h0,         1, 1, 32'h0,         32'h0,         4'b0000, 0, 32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0403, 32'h0,         32'h0,         1, 1, 32'h0,         32'h0,         4'b0000, 0, 32'h0,         0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0402, 32'h0,         32'h8001_1234, 1, 0, 32'h0000_0400, 32'h0,         4'b1100, 0, 32'hFFFF_8001, 1, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0201, 32'h0,         32'h0000_7F00, 2, 0, 32'h0000_0200, 32'h0,         4'b0010, 0, 32'h0000_007F, 1, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0500, 32'h0,         32'hCAFE_F00D, 4, 0, 32'h0000_0500, 32'h0,         4'b1111, 0, 32'hCAFE_F00D, 1, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0600, 32'h0,         32'h0,         0, 0, 32'h0000_0600, 32'h0,         4'b1111, 0, 32'h0000_0000, 0, 1));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0502, 32'h0000_00A5, 32'h0,         1, 0, 32'h0000_0500, 32'hA5A5_A5A5, 4'b0100, 1, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 1, 3'b000, 32'h0000_0700, 32'h1122_3344, 32'hFFFF_FFFF, 1, 0, 32'h0000_0700, 32'h1122_3344, 4'b1111, 1, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 1, 3'b011, 32'h0000_0713, 32'h0000_005A, 32'h0,         1, 0, 32'h0000_0710, 32'h5A5A_5A5A, 4'b1000, 1, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0000_0720, 32'h0,         32'h89AB_CDEF, 2, 0, 32'h0000_0720, 32'h0,         4'b1111, 0, 32'h89AB_CDEF, 1, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0721, 32'h0,         32'h0,         1, 1, 32'h0,         32'h0,         4'b0000, 0, 32'h0,         0, 0));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_req_we", {30'd0, bus_req, bus_we}, 32'd0);
    chk("rst_pulses", {30'd0, rdata_valid, bus_err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_stall_mis", {30'd0, stall, misalign}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // reset during BUSY, late ack afterwards
    cur_vec = 100;
    @(negedge clk);
    mem_read = 1'b1; dm_type = 3'b000; addr = 32'h0000_0800;
    @(negedge clk);
    #1;
    chk("rstmid_busy", 32'(bus_req), 32'd1);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h1234_5678;
    #1;
    chk("rstmid_req", 32'(bus_req), 32'd0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);
    chk("rstmid_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("rstmid_late_ack", {30'd0, rdata_valid, bus_req}, 32'd0);
    chk("rstmid_rdata2", rdata, 32'd0);
    chk("rstmid_state2", 32'(state_dbg), 32'd0);

    // back-to-back: load right after the reset sequence still works
    cur_vec = 101;
    run_vec(mk(1, 0, 3'b110, 32'h0000_0900, 32'h0, 32'h0000_F00D, 1, 0,
               32'h0000_0900, 32'h0, 4'b0011, 0, 32'h0000_F00D, 1, 0));

    repeat (2) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
